// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key-event handshake and status between the keypad scanner
// (master) and the guess-entry logic (slave).
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overflow;

  modport master (output key_code, key_valid, key_held, overflow, input key_ready);
  modport slave  (input key_code, key_valid, key_held, overflow, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes the 4x4 Pmod keypad columns, debounces whole scan frames
// and emits one key code per press. Define KEYPAD_REPEAT_EN for held-key auto-repeat.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV      = 100000,
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned REPEAT_FRAMES = 125
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [3:0]       col,
  input  logic [3:0]       row,
  keypad_scanner_if.master kp
);

  localparam int unsigned       DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]        DEB_LAST = 4'(DEBOUNCE - 1);
  // Nibble {col_idx, row_bit} holds the key code at that matrix position.
  localparam logic [63:0]       KEY_MAP  = 64'hDCBA_E963_F852_0741;

  if (SCAN_DIV < 4 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_FRAMES < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED, S_REL} state_e;
  typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI} frame_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  frame_e           acc_q, acc_d;
  logic [3:0]       acc_code_q, acc_code_d;
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             emit_q, emit_d;
  logic [3:0]       emit_code_q, emit_code_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             overflow_q, overflow_d;

  logic [2:0] hits;
  logic [1:0] hit_row;
  logic [3:0] col_code;
  frame_e     frame_res;
  logic [3:0] frame_code;
  logic       sample, frame_end, single, same, press_emit, rep_fire, accept;

  // Scan timing, row synchroniser and per-frame key accumulation.
  always_comb begin
    div_d      = div_q;
    idx_d      = idx_q;
    row_s1_d   = row;
    row_s2_d   = row_s1_q;
    acc_d      = acc_q;
    acc_code_d = acc_code_q;
    hits       = '0;
    hit_row    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row_s2_q[i]) begin
        hits    = hits + 3'd1;
        hit_row = 2'(i);
      end
    end
    col_code   = KEY_MAP[{idx_q, hit_row, 2'b00} +: 4];
    frame_res  = acc_q;
    frame_code = acc_code_q;
    if (hits > 3'd1) begin
      frame_res = F_MULTI;
    end else if (hits == 3'd1) begin
      if (acc_q == F_NONE) begin
        frame_res  = F_SINGLE;
        frame_code = col_code;
      end else begin
        frame_res = F_MULTI;
      end
    end
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (idx_q == 2'd3);
    if (sample) begin
      div_d      = '0;
      idx_d      = idx_q + 2'd1;
      acc_d      = frame_end ? F_NONE : frame_res;
      acc_code_d = frame_code;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  assign single = (frame_res == F_SINGLE);
  assign same   = single && (frame_code == code_q);

  // Debounce FSM, advanced only on frame ends; multi-key frames count as no key.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    press_emit = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        S_IDLE: begin
          if (single) begin
            code_d = frame_code;
            cnt_d  = 4'd1;
            if (DEB_LAST == 4'd0) begin
              state_d    = S_PRESSED;
              press_emit = 1'b1;
            end else begin
              state_d = S_CAND;
            end
          end
        end
        S_CAND: begin
          if (!single) begin
            state_d = S_IDLE;
          end else if (!same) begin
            code_d = frame_code;
            cnt_d  = 4'd1;
          end else if (cnt_q >= DEB_LAST) begin
            state_d    = S_PRESSED;
            press_emit = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_PRESSED: begin
          if (!single) begin
            cnt_d   = 4'd1;
            state_d = (DEB_LAST == 4'd0) ? S_IDLE : S_REL;
          end
        end
        S_REL: begin
          if (!single) begin
            if (cnt_q >= DEB_LAST) state_d = S_IDLE;
            else                   cnt_d   = cnt_q + 4'd1;
          end else if (same) begin
            state_d = S_PRESSED;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned      REP_W    = $clog2(REPEAT_FRAMES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
  logic [REP_W-1:0] rep_q, rep_d;

  // Leaving PRESSED only happens on a keyless frame, so clearing there covers it.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_q != S_PRESSED) begin
      rep_d = '0;
    end else if (frame_end) begin
      if (!single) begin
        rep_d = '0;
      end else if (same) begin
        if (rep_q == REP_LAST) begin
          rep_fire = 1'b1;
          rep_d    = '0;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Press and repeat emissions never coincide; both carry the current frame code.
  always_comb begin
    emit_d      = press_emit || rep_fire;
    emit_code_d = frame_code;
  end

  always_comb begin
    accept      = key_valid_q && kp.key_ready;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overflow_d  = overflow_q;
    if (emit_q) begin
      if (!key_valid_q || accept) begin
        key_code_d  = emit_code_q;
        key_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (accept) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      idx_q       <= '0;
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      acc_q       <= F_NONE;
      acc_code_q  <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      emit_q      <= 1'b0;
      emit_code_q <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      acc_q       <= acc_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      emit_q      <= emit_d;
      emit_code_q <= emit_code_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign col          = ~(4'b0001 << idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state_q == S_PRESSED) || (state_q == S_REL);
  assign kp.overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driving the rows, frame-level reference
// model of debounce/handshake, per-cycle compare plus literal event checks.
`timescale 1ns/1ps
module tb_keypad_scanner;
  localparam int SD = 4, DB = 2, RF = 3;
  localparam int FRAME = 4 * SD;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keys  = '0;
  logic        ready = 1'b1;

  int total = 0;
  int bad   = 0;

  // Reference model state (plain integers, -1 = no key).
  int mt = 0, acc = -1, run_code = -1, run_len = 0, quiet = 0, rep = 0;
  int pend_code = 0, m_code = 0;
  bit pend = 1'b0, m_valid = 1'b0, m_ovf = 1'b0;
  int evq[$];
  logic [3:0] seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  keypad_scanner_if kif();
  assign kif.key_ready = ready;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT_FRAMES(RF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .col   (col),
    .row   (row),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  function automatic int key_col(input int k);
    case (k)
      1, 4, 7, 0:   return 0;
      2, 5, 8, 15:  return 1;
      3, 6, 9, 14:  return 2;
      default:      return 3;
    endcase
  endfunction

  function automatic int key_row(input int k);
    case (k)
      1, 2, 3, 10:  return 0;
      4, 5, 6, 11:  return 1;
      7, 8, 9, 12:  return 2;
      default:      return 3;
    endcase
  endfunction

  // Physical matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int k = 0; k < 16; k++)
      if (keys[k] && !col[key_col(k)]) row[key_row(k)] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ev(input int i);
    if (i < evq.size()) return evq[i];
    return -1;
  endfunction

  // Reference model: whole frames of key state in, emitted events out.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mt = 0; acc = -1; run_code = -1; run_len = 0; quiet = 0; rep = 0;
      pend = 1'b0; m_code = 0; m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      if (pend) begin
        if (!m_valid || ready) begin m_code = pend_code; m_valid = 1'b1; end
        else m_ovf = 1'b1;
        pend = 1'b0;
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      if (mt % FRAME == FRAME - 1) begin
        int r;
        r = -1;
        if ($countones(keys) == 1)
          for (int k = 0; k < 16; k++) if (keys[k]) r = k;
        if (acc < 0) begin
          if (r >= 0) begin
            if (run_len > 0 && r == run_code) run_len++;
            else begin run_code = r; run_len = 1; end
            if (run_len == DB) begin
              acc = r; quiet = 0; rep = 0; pend = 1'b1; pend_code = r;
            end
          end else begin
            run_len = 0;
          end
        end else if (r == acc) begin
`ifdef KEYPAD_REPEAT_EN
          if (quiet == 0) begin
            rep++;
            if (rep == RF) begin pend = 1'b1; pend_code = acc; rep = 0; end
          end
`endif
          quiet = 0;
        end else if (r < 0) begin
          quiet++;
          rep = 0;
          if (quiet == DB) begin acc = -1; run_len = 0; end
        end
      end
      mt++;
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    logic [3:0] exp_col;
    @(negedge clk);
    exp_col = 4'hF ^ (4'h1 << ((mt / SD) % 4));
    check("col", int'(col), int'(exp_col));
    check("key_valid", int'(kif.key_valid), int'(m_valid));
    check("key_code", int'(kif.key_code), m_code);
    check("key_held", int'(kif.key_held), (acc >= 0) ? 1 : 0);
    check("overflow", int'(kif.overflow), int'(m_ovf));
    if (rst_n && kif.key_valid && ready) evq.push_back(int'(kif.key_code));
  end

  task automatic frames(input int n);
    repeat (FRAME * n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2 * FRAME + 8 && !ok; n++) begin
      @(posedge clk);
      #1;
      if (mt % FRAME == 0) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL align: no frame boundary within budget");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, int'(col), 'he);
    check({tag, "_valid"}, int'(kif.key_valid), 0);
    check({tag, "_code"}, int'(kif.key_code), 0);
    check({tag, "_held"}, int'(kif.key_held), 0);
    check({tag, "_ovf"}, int'(kif.overflow), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("col_seq", int'(col), int'(seq[i / 4]));
    end
    align();

    // Clean press of 5, consumer always ready.
    keys = 16'h1 << 5;
    frames(3);
    check("held_5", int'(kif.key_held), 1);
    keys = '0;
    frames(3);
    check("ev_count_5", evq.size(), 1);
    check("ev_code_5", ev(0), 5);

    // Bouncing 9: present, absent, present twice.
    keys = 16'h1 << 9; frames(1);
    keys = '0;         frames(1);
    keys = 16'h1 << 9; frames(2);
    keys = '0;         frames(3);
    check("ev_count_9", evq.size(), 2);
    check("ev_code_9", ev(1), 9);

    // Two keys at once are never reported; A afterwards is.
    keys = (16'h1 << 1) | (16'h1 << 2);
    frames(4);
    check("ev_count_multi", evq.size(), 2);
    keys = '0;          frames(2);
    keys = 16'h1 << 10; frames(3);
    keys = '0;          frames(3);
    check("ev_count_a", evq.size(), 3);
    check("ev_code_a", ev(2), 10);

    // Consumer stalled: 3 pends, 7 is dropped and flags overflow.
    ready = 1'b0;
    keys = 16'h1 << 3; frames(3);
    keys = '0;         frames(3);
    keys = 16'h1 << 7; frames(3);
    keys = '0;         frames(3);
    check("stall_valid", int'(kif.key_valid), 1);
    check("stall_code", int'(kif.key_code), 3);
    check("stall_ovf", int'(kif.overflow), 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain_valid", int'(kif.key_valid), 0);
    check("ev_code_3", ev(3), 3);

    // Reset while a candidate is being debounced.
    align();
    keys = 16'h1 << 6;
    frames(1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_cand");
    keys = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset while an event is pending.
    ready = 1'b0;
    keys = 16'h1 << 2;
    frames(3);
    check("pend_valid", int'(kif.key_valid), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_pend");
    keys = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;

    // Long hold of 0: accept frame plus eight more.
    keys = 16'h1 << 0;
    frames(10);
    keys = '0;
    frames(3);
`ifdef KEYPAD_REPEAT_EN
    check("ev_count_hold", evq.size(), 7);
    check("ev_hold_0", ev(4), 0);
    check("ev_hold_3", ev(5), 0);
    check("ev_hold_6", ev(6), 0);
`else
    check("ev_count_hold", evq.size(), 5);
    check("ev_hold_0", ev(4), 0);
`endif

    frames(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
